cursor_ctrl: RTL

CURSOR_CTRL -- requirements
Module: cursor_ctrl

---
 rtl/cursor_pkg.sv | 32 +++
 rtl/cursor_axis.sv | 92 +++++++++
 rtl/cursor_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cursor_pkg.sv
// cursor_pkg -- shared types and helpers for the cursor controller.
//
// Contents:
//   dir_t       move codes on the dir input (0 none, 1 up, 2 down, 3 left, 4 right)
//   state_t     acceleration FSM states (IDLE / MOVE / ACCEL)
//   base_step   step size before any acceleration doubling
//   dir_is_move 1 when a dir code requests a move (codes 5-7 count as none)
package cursor_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    ACCEL = 2'd2
  } state_t;

  function automatic int base_step(input logic fast, input int step, input int fast_step);
    return fast ? fast_step : step;
  endfunction

  function automatic logic dir_is_move(input logic [2:0] d);
    return (d >= DIR_UP) && (d <= DIR_RIGHT);
  endfunction

endpackage

// File: rtl/cursor_axis.sv
// cursor_axis -- one coordinate of the cursor: step, clamp/wrap and edge detect.
//
// Parameters:
//   WIDTH           coordinate width
//   MIN / MAX       inclusive bounds of this axis
//   INIT            position loaded by reset
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   en              update enable (low while reset release is being retimed)
//   inc / dec       move this axis up or down by step this frame (exclusive)
//   wrap_en         1 = jump to the opposite bound when crossing, 0 = clamp
//   step            step magnitude, WIDTH+2 bits
//   pos             registered position
//   moved           combinational: next position differs from current
//   hit_edge        combinational: this update hit or crossed a bound
module cursor_axis
  import cursor_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int MIN   = 0,
  parameter int MAX   = 639,
  parameter int INIT  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             wrap_en,
  input  logic [WIDTH+1:0] step,
  output logic [WIDTH-1:0] pos,
  output logic             moved,
  output logic             hit_edge
);

  localparam int SW = WIDTH + 2;

  // Bad bounds must stop the build rather than produce a silently wrong cursor.
  if (MIN > INIT || INIT > MAX || MAX >= (1 << WIDTH)) begin : g_param_check
    $error("cursor_axis: require MIN <= INIT <= MAX < 2**WIDTH");
  end

  localparam logic signed [SW-1:0] MIN_S = SW'(MIN);
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX);
  localparam logic [WIDTH-1:0]     MIN_U = WIDTH'(MIN);
  localparam logic [WIDTH-1:0]     MAX_U = WIDTH'(MAX);
  localparam logic [WIDTH-1:0]     INIT_U = WIDTH'(INIT);

  logic [WIDTH-1:0]     pos_q, pos_d;
  logic signed [SW-1:0] cur_s, nxt_s;
  logic                 hit;

  always_comb begin
    // Two extra bits: one for the sign of an underflow, one for headroom
    // above 2**WIDTH, so out-of-range results are never aliased.
    cur_s = signed'({2'b00, pos_q});
    nxt_s = cur_s;
    if (inc) begin
      nxt_s = cur_s + signed'(step);
    end else if (dec) begin
      nxt_s = cur_s - signed'(step);
    end

    pos_d = pos_q;
    hit   = 1'b0;
    if (en && (inc || dec)) begin
      if (nxt_s > MAX_S) begin
        pos_d = wrap_en ? MIN_U : MAX_U;
        hit   = 1'b1;
      end else if (nxt_s < MIN_S) begin
        pos_d = wrap_en ? MAX_U : MIN_U;
        hit   = 1'b1;
      end else begin
        pos_d = nxt_s[WIDTH-1:0];
        hit   = (nxt_s == MIN_S) || (nxt_s == MAX_S);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= INIT_U;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos      = pos_q;
  assign moved    = (pos_d != pos_q);
  assign hit_edge = hit;

endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl -- frame-rate cursor position controller.
//
// Optional feature: define CURSOR_ACCEL_EN to compile in the hold-to-accelerate
// FSM (IDLE/MOVE/ACCEL) and its held-frame counter; the step doubles in ACCEL.
// Without the macro the step is always the base step.
//
// Ports:
//   frame_clk      sole clock, one update per rising edge
//   Reset_n        asynchronous active-low reset, release retimed to frame_clk
//   dir[2:0]       0 none, 1 up, 2 down, 3 left, 4 right, 5-7 none
//   fast           use FAST_STEP instead of STEP
//   wrap_en        1 = wrap to opposite bound, 0 = clamp
//   pos_x, pos_y   registered cursor position
//   moving         registered: last update changed the position
//   at_edge        registered: last update hit or crossed a bound
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int WIDTH        = 10,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 32,
  parameter int Y_MAX        = 479,
  parameter int X_INIT       = 100,
  parameter int Y_INIT       = 32,
  parameter int STEP         = 1,
  parameter int FAST_STEP    = 2,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic             frame_clk,
  input  logic             Reset_n,
  input  logic [2:0]       dir,
  input  logic             fast,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] pos_x,
  output logic [WIDTH-1:0] pos_y,
  output logic             moving,
  output logic             at_edge
);

  localparam int SW = WIDTH + 2;

  // Reset release: run_q rises on the first edge after Reset_n goes high and
  // the state flops act as the second stage, so the first move lands on the
  // second edge after release. Assertion stays fully asynchronous.
  logic run_q, run_d;
  assign run_d = 1'b1;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  // Direction decode into per-axis controls.
  logic x_inc, x_dec, y_inc, y_dec;
  assign x_inc = (dir == DIR_RIGHT);
  assign x_dec = (dir == DIR_LEFT);
  assign y_inc = (dir == DIR_DOWN);
  assign y_dec = (dir == DIR_UP);

  logic [SW-1:0] base_step_w;
  logic [SW-1:0] step_w;
  assign base_step_w = SW'(base_step(fast, STEP, FAST_STEP));

`ifdef CURSOR_ACCEL_EN
  localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(ACCEL_FRAMES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       last_dir_q, last_dir_d;
  logic             dir_ok;

  assign dir_ok = dir_is_move(dir);

  // State register.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_dir_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
    end
  end

  // Next state. fast/wrap_en are deliberately absent: toggling them never
  // disturbs the hold count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dir_d = last_dir_q;
    if (run_q) begin
      if (!dir_ok) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        last_dir_d = dir;
        case (state_q)
          IDLE: begin
            state_d = MOVE;
            cnt_d   = CNT_W'(1);
          end
          MOVE, ACCEL: begin
            if (dir != last_dir_q) begin
              // New direction: restart the hold, this frame counts as 1.
              state_d = MOVE;
              cnt_d   = CNT_W'(1);
            end else begin
              if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
              end
              if (cnt_d == CNT_SAT) begin
                state_d = ACCEL;
              end
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // Output: the step used this frame depends on the state before the edge.
  always_comb begin
    step_w = base_step_w;
    if (state_q == ACCEL) begin
      step_w = base_step_w << 1;
    end
  end
`else
  always_comb begin
    step_w = base_step_w;
  end
`endif

  logic [WIDTH-1:0] pos_x_w, pos_y_w;
  logic             moved_x, moved_y, hit_x, hit_y;

  cursor_axis #(
    .WIDTH (WIDTH),
    .MIN   (X_MIN),
    .MAX   (X_MAX),
    .INIT  (X_INIT)
  ) u_axis_x (
    .clk      (frame_clk),
    .rst_n    (Reset_n),
    .en       (run_q),
    .inc      (x_inc),
    .dec      (x_dec),
    .wrap_en  (wrap_en),
    .step     (step_w),
    .pos      (pos_x_w),
    .moved    (moved_x),
    .hit_edge (hit_x)
  );

  cursor_axis #(
    .WIDTH (WIDTH),
    .MIN   (Y_MIN),
    .MAX   (Y_MAX),
    .INIT  (Y_INIT)
  ) u_axis_y (
    .clk      (frame_clk),
    .rst_n    (Reset_n),
    .en       (run_q),
    .inc      (y_inc),
    .dec      (y_dec),
    .wrap_en  (wrap_en),
    .step     (step_w),
    .pos      (pos_y_w),
    .moved    (moved_y),
    .hit_edge (hit_y)
  );

  logic moving_q, moving_d;
  logic at_edge_q, at_edge_d;

  always_comb begin
    moving_d  = run_q & (moved_x | moved_y);
    at_edge_d = run_q & (hit_x | hit_y);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      moving_q  <= 1'b0;
      at_edge_q <= 1'b0;
    end else begin
      moving_q  <= moving_d;
      at_edge_q <= at_edge_d;
    end
  end

  assign pos_x   = pos_x_w;
  assign pos_y   = pos_y_w;
  assign moving  = moving_q;
  assign at_edge = at_edge_q;

endmodule
